// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM width measurement path.
package pwm_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam logic [CNT_W_DEFAULT-1:0] WIDTH_SAT = '1;
  localparam int GLITCH_W = 8;

  typedef enum logic {IDLE, COUNT} pwm_state_t;

endpackage

// File: rtl/pwm_width_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module pwm_width_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_pop;
  logic              w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pwm_width_meter.sv
// Measures cycles between control-unit start/stop strobes, drops glitches,
// and queues accepted widths on a valid/ready stream.
module pwm_width_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int MIN_WIDTH  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                counter_reset,
  input  logic                result_latch,
  output logic [CNT_W-1:0]    width_out,
  output logic                width_valid,
  input  logic                width_ready,
  output logic                overrun,
  input  logic                clear_overrun,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic                busy
);

  pwm_state_t          r_state;
  logic [CNT_W-1:0]    r_count;
  logic                r_busy;
  logic                r_overrun;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_stop;
  logic             w_glitch;
  logic             w_push_req;
  logic [CNT_W-1:0] w_pop_data;

  assign w_pop      = !w_empty && width_ready;
  assign w_stop     = (r_state == COUNT) && result_latch;
  assign w_glitch   = w_stop && (r_count < CNT_W'(MIN_WIDTH));
  assign w_push_req = w_stop && !w_glitch;

  // The counter loads 1 on start so that a stop N cycles later reads exactly N.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (counter_reset) begin
            r_count <= CNT_W'(1);
            r_state <= COUNT;
            r_busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (counter_reset) begin
            r_count <= CNT_W'(1);
          end else if (result_latch) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_glitch_cnt <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_glitch && (r_glitch_cnt != {GLITCH_W{1'b1}}))
        r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
      // A new drop outranks a simultaneous clear.
      if (w_push_req && w_full && !w_pop)
        r_overrun <= 1'b1;
      else if (clear_overrun)
        r_overrun <= 1'b0;
    end
  end

  pwm_width_fifo #(
    .DATA_W (CNT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push_req),
    .push_data (r_count),
    .full      (w_full),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .empty     (w_empty)
  );

  assign width_out   = w_pop_data;
  assign width_valid = !w_empty;
  assign overrun     = r_overrun;
  assign glitch_cnt  = r_glitch_cnt;
  assign busy        = r_busy;

endmodule

// File: tb/tb_pwm_width_meter.sv
// Directed bench for pwm_width_meter with hand-computed expected widths.
module tb_pwm_width_meter;

  logic        clock;
  logic        reset_n;
  logic        counter_reset;
  logic        result_latch;
  logic [15:0] width_out;
  logic        width_valid;
  logic        width_ready;
  logic        overrun;
  logic        clear_overrun;
  logic [7:0]  glitch_cnt;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  pwm_width_meter #(
    .CNT_W      (16),
    .MIN_WIDTH  (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .counter_reset (counter_reset),
    .result_latch  (result_latch),
    .width_out     (width_out),
    .width_valid   (width_valid),
    .width_ready   (width_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .glitch_cnt    (glitch_cnt),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start strobe, then stop strobe n cycles later.
  task automatic measure(input int n);
    counter_reset = 1'b1;
    step();
    counter_reset = 1'b0;
    repeat (n - 1) step();
    result_latch = 1'b1;
    step();
    result_latch = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    counter_reset = 1'b0;
    result_latch  = 1'b0;
    width_ready   = 1'b0;
    clear_overrun = 1'b0;
    repeat (3) step();
    chk("rst_width_out", 32'(width_out), 32'd0);
    chk("rst_valid", 32'(width_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_glitch", 32'(glitch_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    step();

    // Stop before any start is ignored.
    result_latch = 1'b1;
    step();
    result_latch = 1'b0;
    chk("idle_stop_valid", 32'(width_valid), 32'd0);
    chk("idle_stop_busy", 32'(busy), 32'd0);

    // Width 100 with the consumer always ready.
    width_ready   = 1'b1;
    counter_reset = 1'b1;
    step();
    counter_reset = 1'b0;
    chk("w100_busy_on", 32'(busy), 32'd1);
    repeat (99) step();
    chk("w100_valid_pre", 32'(width_valid), 32'd0);
    result_latch = 1'b1;
    step();
    result_latch = 1'b0;
    chk("w100_valid", 32'(width_valid), 32'd1);
    chk("w100_data", 32'(width_out), 32'd100);
    chk("w100_busy_off", 32'(busy), 32'd0);
    step();
    chk("w100_valid_drop", 32'(width_valid), 32'd0);

    // Glitch boundary around MIN_WIDTH.
    measure(1);
    chk("w1_valid", 32'(width_valid), 32'd0);
    chk("w1_glitch", 32'(glitch_cnt), 32'd1);
    measure(2);
    chk("w2_valid", 32'(width_valid), 32'd1);
    chk("w2_data", 32'(width_out), 32'd2);
    chk("w2_glitch", 32'(glitch_cnt), 32'd1);
    step();

    // Counter saturation.
    measure(70000);
    chk("sat_valid", 32'(width_valid), 32'd1);
    chk("sat_data", 32'(width_out), 32'h0000_FFFF);
    step();
    chk("sat_popped", 32'(width_valid), 32'd0);

    // Fill the queue and overflow it with the consumer stalled.
    width_ready = 1'b0;
    measure(10);
    measure(20);
    measure(30);
    measure(40);
    chk("fill_overrun", 32'(overrun), 32'd0);
    chk("fill_head", 32'(width_out), 32'd10);
    measure(50);
    chk("ovf_overrun", 32'(overrun), 32'd1);
    chk("ovf_head_stable", 32'(width_out), 32'd10);
    width_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(width_valid), 32'd1);
      chk("drain_data", 32'(width_out), 32'((i + 1) * 10));
      step();
    end
    chk("drain_empty", 32'(width_valid), 32'd0);
    chk("drain_overrun_sticky", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'd0);

    // Both strobes together at count 25, then stop 15 cycles later.
    counter_reset = 1'b1;
    step();
    counter_reset = 1'b0;
    repeat (24) step();
    counter_reset = 1'b1;
    result_latch  = 1'b1;
    step();
    counter_reset = 1'b0;
    result_latch  = 1'b0;
    chk("both_valid", 32'(width_valid), 32'd1);
    chk("both_data", 32'(width_out), 32'd25);
    chk("both_busy", 32'(busy), 32'd1);
    step();
    chk("both_popped", 32'(width_valid), 32'd0);
    repeat (13) step();
    result_latch = 1'b1;
    step();
    result_latch = 1'b0;
    chk("restart_valid", 32'(width_valid), 32'd1);
    chk("restart_data", 32'(width_out), 32'd15);
    step();

    // Asynchronous reset mid-measurement with two samples queued.
    width_ready = 1'b0;
    measure(5);
    measure(6);
    chk("pre_rst_valid", 32'(width_valid), 32'd1);
    counter_reset = 1'b1;
    step();
    counter_reset = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(width_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_width_out", 32'(width_out), 32'd0);
    chk("arst_glitch", 32'(glitch_cnt), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    result_latch = 1'b1;
    step();
    result_latch = 1'b0;
    chk("post_rst_stop_valid", 32'(width_valid), 32'd0);
    chk("post_rst_stop_busy", 32'(busy), 32'd0);
    measure(7);
    chk("post_rst_valid", 32'(width_valid), 32'd1);
    chk("post_rst_data", 32'(width_out), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
